// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, shift codes,
// FSM state encoding and a signed-overflow helper.
package regseq_pkg;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD_A = 2'b01,
        ST_RD_B = 2'b10,
        ST_WB   = 2'b11
    } state_t;

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/regseq_alu.sv
// Combinational datapath of the sequencer: operand shifter, immediate
// sign-extension, ADD/AND and flag generation. Shifter enabled by SEQ_SHIFT_EN.
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [7:0]    imm8,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] b_shift,
    output logic [DW-1:0] result,
    output logic          z,
    output logic          n,
    output logic          v
);

    logic [DW-1:0] sum_s;
    logic [DW-1:0] sext_s;

    assign sum_s  = a + b;
    assign sext_s = {{(DW-8){imm8[7]}}, imm8};

`ifdef SEQ_SHIFT_EN
    // Operand shifter applied to the second read port value.
    always_comb begin
        case (shift)
            SH_NONE: b_shift = rd_data;
            SH_LSL:  b_shift = {rd_data[DW-2:0], 1'b0};
            SH_LSR:  b_shift = {1'b0, rd_data[DW-1:1]};
            SH_ASR:  b_shift = {rd_data[DW-1], rd_data[DW-1:1]};
            default: b_shift = rd_data;
        endcase
    end
`else
    logic unused_shift_s;
    assign unused_shift_s = ^shift;
    assign b_shift        = rd_data;
`endif

    // Result select and flag generation.
    always_comb begin
        case (op)
            OP_MOVI: result = sext_s;
            OP_MOV:  result = b;
            OP_ADD:  result = sum_s;
            OP_AND:  result = a & b;
            default: result = b;
        endcase
        z = (result == {DW{1'b0}});
        n = result[DW-1];
        if (op == OP_ADD) begin
            v = add_ovf(a[DW-1], b[DW-1], sum_s[DW-1]);
        end else begin
            v = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accepts one decoded op per handshake and walks
// IDLE/RD_A/RD_B/WB to read operands, compute and write back (SEQ_SHIFT_EN optional).
module regfile_sequencer
    import regseq_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rn,
    input  logic [AW-1:0] in_rm,
    input  logic [7:0]    in_imm8,
    input  logic [1:0]    in_shift,
    output logic [AW-1:0] rf_readnum,
    input  logic [DW-1:0] rf_data_out,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [DW-1:0] rf_data_in,
    output logic          done,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v
);

    state_t        state_r, state_s;
    logic [1:0]    op_r, shift_r;
    logic [AW-1:0] rd_r, rn_r, rm_r;
    logic [7:0]    imm8_r;
    logic [DW-1:0] a_r, b_r;
    logic          flag_z_r, flag_n_r, flag_v_r;
    logic          accept_s;
    logic [DW-1:0] b_shift_s, result_s;
    logic          z_s, n_s, v_s;

    assign accept_s = in_valid && (state_r == ST_IDLE);

    regseq_alu #(.DW(DW)) u_alu (
        .op      (op_r),
        .shift   (shift_r),
        .a       (a_r),
        .b       (b_r),
        .imm8    (imm8_r),
        .rd_data (rf_data_out),
        .b_shift (b_shift_s),
        .result  (result_s),
        .z       (z_s),
        .n       (n_s),
        .v       (v_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    case (in_op)
                        OP_MOVI: state_s = ST_WB;
                        OP_MOV:  state_s = ST_RD_B;
                        default: state_s = ST_RD_A;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_A: state_s = ST_RD_B;
            ST_RD_B: state_s = ST_WB;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register and latched fields only.
    always_comb begin
        in_ready    = 1'b0;
        rf_readnum  = {AW{1'b0}};
        rf_writenum = {AW{1'b0}};
        rf_write    = 1'b0;
        rf_data_in  = {DW{1'b0}};
        done        = 1'b0;
        case (state_r)
            ST_IDLE: in_ready   = 1'b1;
            ST_RD_A: rf_readnum = rn_r;
            ST_RD_B: rf_readnum = rm_r;
            ST_WB: begin
                rf_writenum = rd_r;
                rf_write    = 1'b1;
                rf_data_in  = result_s;
                done        = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign flag_z = flag_z_r;
    assign flag_n = flag_n_r;
    assign flag_v = flag_v_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Instruction latch on accept; operand latches in their read states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 2'b00;
            shift_r <= 2'b00;
            rd_r    <= {AW{1'b0}};
            rn_r    <= {AW{1'b0}};
            rm_r    <= {AW{1'b0}};
            imm8_r  <= 8'h00;
            a_r     <= {DW{1'b0}};
            b_r     <= {DW{1'b0}};
        end else begin
            if (accept_s) begin
                op_r    <= in_op;
                shift_r <= in_shift;
                rd_r    <= in_rd;
                rn_r    <= in_rn;
                rm_r    <= in_rm;
                imm8_r  <= in_imm8;
            end
            if (state_r == ST_RD_A) begin
                a_r <= rf_data_out;
            end
            if (state_r == ST_RD_B) begin
                b_r <= b_shift_s;
            end
        end
    end

    // Flags change only at the end of an ADD/AND writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_v_r <= 1'b0;
        end else if ((state_r == ST_WB) && ((op_r == OP_ADD) || (op_r == OP_AND))) begin
            flag_z_r <= z_s;
            flag_n_r <= n_s;
            flag_v_r <= v_s;
        end
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Instruction-driven initiator for the 8×16-bit register file: accepts one decoded operation at a time over a valid/ready handshake and drives the register file's `readnum`/`writenum`/`write`/`data_in` ports, sampling `data_out` to execute it. Sits between instruction decode and the register file, with a small ALU. Produces status flags and a completion pulse per operation.

## Interface
- `DW`, 16, datapath width; must match the register file.
- `AW`, 3, register index width (8 registers).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: sequencer idle, accepts an operation.
- `in_op` in 2: 00 MOVI, 01 MOV, 10 ADD, 11 AND.
- `in_rd`, `in_rn`, `in_rm` in AW: destination, first source, second source.
- `in_imm8` in 8: immediate for MOVI.
- `in_shift` in 2: Rm operand shift, used only when `SEQ_SHIFT_EN` is defined.
- `rf_readnum` out AW: register file read select.
- `rf_data_out` in DW: register file combinational read data.
- `rf_writenum` out AW: register file write select.
- `rf_write` out 1: register file write enable.
- `rf_data_in` out DW: register file write data.
- `done` out 1: one-cycle pulse during the writeback cycle.
- `flag_z`, `flag_n`, `flag_v` out 1: status from the last ADD/AND.

## Operation
- FSM states: IDLE, RD_A, RD_B, WB.
- IDLE: `in_ready`=1. On `in_valid`, latch op, rd, rn, rm, imm8 and shift. Next state:
  - MOVI → WB
  - MOV → RD_B
  - ADD/AND → RD_A
- RD_A: `rf_readnum`=rn. Latch `rf_data_out` into A. Next state RD_B.
- RD_B: `rf_readnum`=rm. Latch the shifted `rf_data_out` into B. Next state WB.
- WB: `rf_write`=1, `rf_writenum`=rd, `rf_data_in`=result, `done`=1. Next state IDLE.
- Results:
  - MOVI: sign-extend imm8 to DW.
  - MOV: B.
  - ADD: (A+B) mod 2^DW.
  - AND: A&B.
- Flags update at the end of WB, for ADD and AND only:
  - Z = result==0.
  - N = result[DW-1].
  - V = signed overflow for ADD; cleared by AND.
- MOVI and MOV leave the flags unchanged.
- All `rf_*` outputs, `in_ready` and `done` are decoded from state and latched fields only. There is no combinational path from `in_*` to outputs.
- Outside RD_A/RD_B, `rf_readnum`=0. Outside WB, `rf_writenum`=0, `rf_data_in`=0 and `rf_write`=0.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1.
  - All `rf_*` outputs 0, `done`=0.
  - Flags 0, operand and instruction latches 0.
- Handshake: an operation transfers on a rising edge with `in_valid`&&`in_ready`. `in_valid` while busy is ignored, and the source must hold it.
- Latency from the accept edge to the WB cycle: MOVI 1 cycle, MOV 2 cycles, ADD/AND 3 cycles. The register file captures on the edge ending WB.
- `in_ready` rises in the cycle after WB. Throughput is 1 op per 2/3/4 cycles for MOVI/MOV/ADD-AND.
- rd equal to rn or rm is legal: operands are latched before WB.
- `rst_n` low mid-operation: immediate return to IDLE and `rf_write` forced 0 asynchronously. No partial write, and the in-flight op is lost.

## Configuration
- `SEQ_SHIFT_EN` defined: B is shifted in RD_B per `in_shift`:
  - 00 none
  - 01 LSL 1
  - 10 LSR 1
  - 11 ASR 1 (replicate bit DW-1)
- The shift also applies to MOV.
- Undefined: `in_shift` is ignored and B is `rf_data_out` unmodified.

## Structure
- Package `regseq_pkg`:
  - opcode constants (OP_MOVI, OP_MOV, OP_ADD, OP_AND)
  - shift codes
  - FSM state encoding
- Sub-module `regseq_alu` (combinational): shifter, sign-extend, add/and, flag generation. The sequencer owns the FSM, latches and flag registers.

## Test plan
- Reset, then MOVI rd=3 imm8=0x85 → WB one cycle after accept, `rf_writenum`=3, `rf_data_in`=0xFF85, `done` pulse; flags stay 0.
- R1=0x7FFF, R2=0x0001, ADD rd=0 rn=1 rm=2 → `rf_readnum` 1 then 2, write 0x8000 to R0, N=1, V=1, Z=0, WB 3 cycles after accept.
- R4=0x00F0, R5=0x0F00, AND rd=4 rn=4 rm=5 → write 0x0000 to R4, Z=1, N=0, V=0.
- `in_valid` held high during ADD with a second op MOV rd=6 rm=4 → second op accepted only in the cycle after WB; R6 receives the ADD result.
- `rst_n` pulsed low during RD_B → `rf_write` never asserted, `in_ready`=1 and all outputs 0 immediately, flags 0.
- With `SEQ_SHIFT_EN`: R7=0x8002, MOV rd=1 rm=7 shift=11 → 0xC001; shift=10 → 0x4001; shift=01 → 0x0004.
